// File: rtl/oh_to_idx_reg.sv
// oh_to_idx_reg: registered one-hot-to-index decoder with a valid/ready stream
// interface. Zero-hot and multi-hot vectors are flagged on out_err and counted
// in a saturating error counter. Bit-to-index mapping matches the companion
// index-to-one-hot encoder, so the two compose to identity.
module oh_to_idx_reg #(
  parameter int NUM_SIGNALS   = 4,
  parameter     DIRECTION     = "LSB0",
  parameter int ERR_CNT_WIDTH = 8,
  localparam int INDEX_WIDTH  = $clog2(NUM_SIGNALS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SIGNALS-1:0]   in_one_hot,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INDEX_WIDTH-1:0]   out_index,
  output logic                     out_err,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam bit LSB0 = (DIRECTION == "LSB0");
  localparam logic [NUM_SIGNALS-1:0] ONE = {{(NUM_SIGNALS-1){1'b0}}, 1'b1};

  logic                   in_xfer;
  logic                   found;
  logic [31:0]            pos;
  logic [31:0]            idx32;
  logic [INDEX_WIDTH-1:0] dec_index;
  logic                   dec_err;
  logic                   zero_hot;
  logic                   multi_hot;

  // Single pipeline register: accept whenever the slot is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  assign zero_hot  = ~|in_one_hot;
  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi_hot = |(in_one_hot & (in_one_hot - ONE));

  // Locate the lowest set bit and map it to an index; zero-hot decodes to 0.
  always_comb begin
    found = 1'b0;
    pos   = 32'd0;
    for (int p = 0; p < NUM_SIGNALS; p++) begin
      if (in_one_hot[p] && !found) begin
        found = 1'b1;
        pos   = 32'(p);
      end
    end
    if (!found)
      idx32 = 32'd0;
    else if (LSB0)
      idx32 = pos;
    else
      idx32 = 32'(NUM_SIGNALS) - 32'd1 - pos;
    dec_index = INDEX_WIDTH'(idx32);
    dec_err   = zero_hot || multi_hot;
  end

  // Output valid flag: set on accept, cleared by a drain with no new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_valid <= 1'b0;
    else if (in_xfer)
      out_valid <= 1'b1;
    else if (out_ready)
      out_valid <= 1'b0;
  end

  // Result register: loads only on accept, so it holds through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_index <= '0;
      out_err   <= 1'b0;
    end else if (in_xfer) begin
      out_index <= dec_index;
      out_err   <= dec_err;
    end
  end

  // Saturating malformed-vector counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (in_xfer && dec_err && (err_count != {ERR_CNT_WIDTH{1'b1}}))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_oh_to_idx_reg.sv
// Directed testbench for oh_to_idx_reg. Four instances cover the default
// configuration, NUM_SIGNALS=5 in both directions, and a 2-bit error counter.
module tb_oh_to_idx_reg;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance: 4 signals, LSB0, 8-bit counter
  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_err, d_err_clr;
  logic [3:0] d_in_oh;
  logic [1:0] d_out_index;
  logic [7:0] d_err_count;

  // 5 signals, MSB0
  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_err, m_err_clr;
  logic [4:0] m_in_oh;
  logic [2:0] m_out_index;
  logic [7:0] m_err_count;

  // 5 signals, LSB0
  logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_err, l_err_clr;
  logic [4:0] l_in_oh;
  logic [2:0] l_out_index;
  logic [7:0] l_err_count;

  // 4 signals, LSB0, 2-bit counter
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err, s_err_clr;
  logic [3:0] s_in_oh;
  logic [1:0] s_out_index;
  logic [1:0] s_err_count;

  oh_to_idx_reg u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_one_hot(d_in_oh), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_index(d_out_index), .out_err(d_out_err), .err_clr(d_err_clr),
    .err_count(d_err_count)
  );

  oh_to_idx_reg #(.NUM_SIGNALS(5), .DIRECTION("MSB0"), .ERR_CNT_WIDTH(8)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_one_hot(m_in_oh), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_index(m_out_index), .out_err(m_out_err), .err_clr(m_err_clr),
    .err_count(m_err_count)
  );

  oh_to_idx_reg #(.NUM_SIGNALS(5), .DIRECTION("LSB0"), .ERR_CNT_WIDTH(8)) u_lsb5 (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_one_hot(l_in_oh), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_index(l_out_index), .out_err(l_out_err), .err_clr(l_err_clr),
    .err_count(l_err_count)
  );

  oh_to_idx_reg #(.NUM_SIGNALS(4), .DIRECTION("LSB0"), .ERR_CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_one_hot(s_in_oh), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_index(s_out_index), .out_err(s_out_err), .err_clr(s_err_clr),
    .err_count(s_err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d_in_valid = 0; d_out_ready = 1; d_err_clr = 0; d_in_oh = '0;
    m_in_valid = 0; m_out_ready = 1; m_err_clr = 0; m_in_oh = '0;
    l_in_valid = 0; l_out_ready = 1; l_err_clr = 0; l_in_oh = '0;
    s_in_valid = 0; s_out_ready = 1; s_err_clr = 0; s_in_oh = '0;
    rst_n = 0;
    #2;
    checks++;
    if ({d_out_valid, d_out_index, d_out_err, d_err_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got v=%b idx=%0d err=%b cnt=%0d, want all 0",
               d_out_valid, d_out_index, d_out_err, d_err_count);
    end
    checks++;
    if (d_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", d_in_ready);
    end
    #10 rst_n = 1;
    tick();
  endtask

  task automatic test_single_decode();
    d_in_valid = 1; d_in_oh = 4'b0100; d_out_ready = 1;
    tick();
    d_in_valid = 0; d_in_oh = 4'b1111;
    checks++;
    if (d_out_valid !== 1'b1 || d_out_index !== 2'd2 || d_out_err !== 1'b0) begin
      errors++;
      $display("FAIL single_decode: got v=%b idx=%0d err=%b want v=1 idx=2 err=0",
               d_out_valid, d_out_index, d_out_err);
    end
    tick();
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got out_valid=%b want 0", d_out_valid);
    end
  endtask

  task automatic test_msb0();
    m_in_valid = 1; m_in_oh = 5'b00010;
    tick();
    m_in_valid = 0;
    checks++;
    if (m_out_valid !== 1'b1 || m_out_index !== 3'd3 || m_out_err !== 1'b0) begin
      errors++;
      $display("FAIL msb0_decode: got v=%b idx=%0d err=%b want v=1 idx=3 err=0",
               m_out_valid, m_out_index, m_out_err);
    end
    tick();
  endtask

  // Encode index i per direction, decode it, require i back; streamed back-to-back.
  task automatic test_round_trip();
    for (int i = 0; i < 5; i++) begin
      logic [4:0] oh_l;
      logic [4:0] oh_m;
      oh_l = '0; oh_l[i] = 1'b1;
      oh_m = '0; oh_m[4-i] = 1'b1;
      l_in_valid = 1; l_in_oh = oh_l;
      m_in_valid = 1; m_in_oh = oh_m;
      tick();
      checks++;
      if (l_out_valid !== 1'b1 || l_out_index !== 3'(i) || l_out_err !== 1'b0) begin
        errors++;
        $display("FAIL round_trip_lsb0[%0d]: got v=%b idx=%0d err=%b want v=1 idx=%0d err=0",
                 i, l_out_valid, l_out_index, l_out_err, i);
      end
      checks++;
      if (m_out_valid !== 1'b1 || m_out_index !== 3'(i) || m_out_err !== 1'b0) begin
        errors++;
        $display("FAIL round_trip_msb0[%0d]: got v=%b idx=%0d err=%b want v=1 idx=%0d err=0",
                 i, m_out_valid, m_out_index, m_out_err, i);
      end
    end
    l_in_valid = 0; m_in_valid = 0;
    tick();
  endtask

  task automatic test_back_pressure();
    d_in_valid = 1; d_in_oh = 4'b1000; d_out_ready = 0;
    tick();
    d_in_oh = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_out_index !== 2'd3) begin
        errors++;
        $display("FAIL stall[%0d]: got in_ready=%b v=%b idx=%0d want in_ready=0 v=1 idx=3",
                 c, d_in_ready, d_out_valid, d_out_index);
      end
      if (c < 2) tick();
    end
    d_out_ready = 1;
    #1;
    checks++;
    if (d_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b want 1", d_in_ready);
    end
    tick();
    d_in_oh = 4'b0010;
    checks++;
    if (d_out_valid !== 1'b1 || d_out_index !== 2'd0 || d_out_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_second: got v=%b idx=%0d err=%b want v=1 idx=0 err=0",
               d_out_valid, d_out_index, d_out_err);
    end
    tick();
    d_in_valid = 0;
    checks++;
    if (d_out_valid !== 1'b1 || d_out_index !== 2'd1) begin
      errors++;
      $display("FAIL stream_third: got v=%b idx=%0d want v=1 idx=1",
               d_out_valid, d_out_index);
    end
    tick();
    checks++;
    if (d_out_valid !== 1'b0 || d_out_index !== 2'd1) begin
      errors++;
      $display("FAIL stream_drain: got v=%b idx=%0d want v=0 idx=1 held",
               d_out_valid, d_out_index);
    end
  endtask

  task automatic test_malformed();
    d_in_valid = 1; d_in_oh = 4'b0000;
    tick();
    d_in_oh = 4'b1010;
    checks++;
    if (d_out_err !== 1'b1 || d_out_index !== 2'd0 || d_err_count !== 8'd1) begin
      errors++;
      $display("FAIL zero_hot: got err=%b idx=%0d cnt=%0d want err=1 idx=0 cnt=1",
               d_out_err, d_out_index, d_err_count);
    end
    tick();
    d_in_valid = 0;
    checks++;
    if (d_out_err !== 1'b1 || d_out_index !== 2'd1 || d_err_count !== 8'd2) begin
      errors++;
      $display("FAIL multi_hot: got err=%b idx=%0d cnt=%0d want err=1 idx=1 cnt=2",
               d_out_err, d_out_index, d_err_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    s_in_valid = 1; s_out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      s_in_oh = (i % 2 == 0) ? 4'b0000 : 4'b0110;
      tick();
      checks++;
      if (s_err_count !== exp_cnt[i] || s_out_err !== 1'b1) begin
        errors++;
        $display("FAIL saturate[%0d]: got cnt=%0d err=%b want cnt=%0d err=1",
                 i, s_err_count, s_out_err, exp_cnt[i]);
      end
    end
    s_in_oh = 4'b1100; s_err_clr = 1;
    tick();
    s_err_clr = 0; s_in_valid = 0;
    checks++;
    if (s_err_count !== 2'd0 || s_out_err !== 1'b1 || s_out_index !== 2'd2) begin
      errors++;
      $display("FAIL clear_priority: got cnt=%0d err=%b idx=%0d want cnt=0 err=1 idx=2",
               s_err_count, s_out_err, s_out_index);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    d_in_valid = 1; d_in_oh = 4'b0011; d_out_ready = 0;
    tick();
    d_in_valid = 0;
    checks++;
    if (d_out_valid !== 1'b1 || d_err_count !== 8'd3) begin
      errors++;
      $display("FAIL pre_reset: got v=%b cnt=%0d want v=1 cnt=3", d_out_valid, d_err_count);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (d_out_valid !== 1'b0 || d_err_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b cnt=%0d want v=0 cnt=0", d_out_valid, d_err_count);
    end
    #1 rst_n = 1;
    tick();
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got in_ready=%b v=%b want in_ready=1 v=0",
               d_in_ready, d_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_decode();
    test_msb0();
    test_round_trip();
    test_back_pressure();
    test_malformed();
    test_saturation();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oh_to_idx_reg.md
Name: oh_to_idx_reg

Overview:
Registered one-hot-to-index decoder with a valid/ready stream interface. It is the inverse of the team's index-to-one-hot encoder and uses the same NUM_SIGNALS and DIRECTION conventions, so the two compose to identity. It sits on grant and select return paths, for example arbiter grants converted back to a requester ID. It flags malformed vectors (zero-hot or multi-hot) and keeps a saturating count of them.

Parameters:
NUM_SIGNALS, 4, width of the one-hot input vector; legal range is 2 or more, and any value (not only a power of 2) is allowed.
DIRECTION, "LSB0", bit-to-index mapping. "LSB0": bit p maps to index p. Any other value: bit p maps to index NUM_SIGNALS-1-p.
ERR_CNT_WIDTH, 8, width of the error counter.
INDEX_WIDTH, $clog2(NUM_SIGNALS), localparam, index width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input vector is valid.
in_ready  output  1  block can accept the input this cycle.
in_one_hot  input  NUM_SIGNALS  one-hot vector to decode.
out_valid  output  1  output register holds a result.
out_ready  input  1  downstream accepts the result.
out_index  output  INDEX_WIDTH  decoded index.
out_err  output  1  the vector that produced this result was not exactly one-hot.
err_clr  input  1  synchronous clear of err_count.
err_count  output  ERR_CNT_WIDTH  saturating count of accepted malformed vectors.

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - out_valid=0, out_index=0, out_err=0, err_count=0.
  - Deassertion is synchronised externally and is not handled inside the block.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and is a single pipeline register, not a skid buffer.
  - Input transfer: in_valid && in_ready at the rising edge.
  - Output transfer: out_valid && out_ready at the rising edge.
- Latency and throughput:
  - A vector accepted at edge N appears on out_index/out_err at edge N, visible in cycle N+1.
  - Full throughput of 1 transfer per cycle while out_ready=1.
- Output hold:
  - While out_valid && !out_ready, out_index and out_err hold stable.
  - in_ready=0 during this stall.
- Drain with no new input:
  - An output transfer with no simultaneous input transfer clears out_valid.
  - out_index and out_err keep their last values; they are don't-care while out_valid=0.
- Decode:
  - Let p = the position of the lowest set bit of in_one_hot.
  - out_index = p if DIRECTION=="LSB0", else NUM_SIGNALS-1-p.
  - Arithmetic is done at 32 bits, then truncated to INDEX_WIDTH.
- Exactly one bit set: out_err=0.
- Zero-hot input: out_err=1, out_index=0.
- Multi-hot input:
  - out_err=1.
  - out_index is decoded from the lowest set bit (LSB priority), independent of DIRECTION.
- in_one_hot is don't-care when in_valid=0 and never affects state.
- Error counter:
  - Increments by 1 on each input transfer whose vector is malformed.
  - Saturates at 2^ERR_CNT_WIDTH-1 and does not wrap.
- err_clr:
  - Forces err_count to 0 on the next edge.
  - It has priority over a simultaneous increment; that error is not counted.
- Reset mid-operation: the in-flight result is discarded, out_valid drops immediately, and the counter clears.
- No other state exists: no FSM beyond the out_valid flag, and no X-propagation on outputs after reset.

Test Plan:
1. Reset and single decode, defaults:
   - Stimulus: rst_n low, then in_one_hot=4'b0100 with in_valid=1 for 1 cycle, out_ready=1.
   - Response: the cycle after acceptance shows out_valid=1, out_index=2, out_err=0; the next cycle shows out_valid=0.
2. MSB0 direction, NUM_SIGNALS=5:
   - Stimulus: in_one_hot=5'b00010.
   - Response: out_index=3.
   - Also sweep every legal one-hot value through the encoder-to-decoder round trip and require identity, for both directions.
3. Back-pressure:
   - Stimulus: a stream of 1000, 0001, 0010 with out_ready held low for 3 cycles after the first accept.
   - Response:
     - in_ready=0 during the stall.
     - out_index holds 3.
     - After release, indices 3, 0, 1 appear in order with no loss or duplication.
     - Back-to-back throughput is 1 per cycle.
4. Malformed input:
   - Stimulus: 4'b0000, then 4'b1010.
   - Response: out_err=1 with index 0, then out_err=1 with index 1; err_count=2.
5. Counter saturation and clear:
   - Stimulus: ERR_CNT_WIDTH=2 and 5 malformed vectors.
   - Response: err_count stops at 3.
   - Then assert err_clr in the same cycle as a malformed accept: err_count=0.
6. Reset mid-stream:
   - Stimulus: drop rst_n while out_valid=1 and out_ready=0.
   - Response: out_valid=0 and err_count=0 immediately, before any clock edge; in_ready=1 after reset.
